// File: rtl/regfile_arbiter.sv
// Two-requester arbiter for the shared single-port register file.
// Round-robin grants; define REGFILE_ARB_FIXED_PRIO_EN to favour requester A.
module regfile_arbiter #(
   parameter int DATA_W   = 16,
   parameter int SEL_W    = 3,
   parameter int NUM_REGS = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [SEL_W-1:0]  a_sel,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic              a_err,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [SEL_W-1:0]  b_sel,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic              b_err,
   output logic [DATA_W-1:0] b_rdata,
   output logic [SEL_W-1:0]  rf_s_in,
   output logic [SEL_W-1:0]  rf_s_out,
   output logic [DATA_W-1:0] rf_d_in,
   output logic              rf_write_en,
   output logic              rf_out_en,
   input  logic [DATA_W-1:0] rf_d_out,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [SEL_W:0] NREG = (SEL_W+1)'(NUM_REGS);

   state_t              state;
   state_t              state_nxt;
   logic                last_b;
   logic                grant_b;
   logic                cur_b;
   logic                cur_we;
   logic                cur_ok;
   logic [SEL_W-1:0]    cur_sel;
   logic [DATA_W-1:0]   cur_wdata;
   logic                win_we;
   logic [SEL_W-1:0]    win_sel;
   logic [DATA_W-1:0]   win_wdata;

   // last_b=1 means B was served last, so A wins the next tie
   always_comb begin
      grant_b = 1'b0;
      if (a_req && b_req) begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
         grant_b = 1'b0;
`else
         grant_b = !last_b;
`endif
      end else begin
         grant_b = b_req;
      end
   end

   always_comb begin
      win_we    = grant_b ? b_we    : a_we;
      win_sel   = grant_b ? b_sel   : a_sel;
      win_wdata = grant_b ? b_wdata : a_wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (a_req || b_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rf_s_in     = '0;
      rf_s_out    = '0;
      rf_d_in     = '0;
      rf_write_en = 1'b0;
      rf_out_en   = 1'b0;
      busy        = (state != IDLE);
      if (state == ACCESS) begin
         rf_s_in     = cur_sel;
         rf_s_out    = cur_sel;
         rf_d_in     = cur_wdata;
         rf_write_en = cur_ok && cur_we;
         rf_out_en   = cur_ok && !cur_we;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_b    <= 1'b1;
         cur_b     <= 1'b0;
         cur_we    <= 1'b0;
         cur_ok    <= 1'b0;
         cur_sel   <= '0;
         cur_wdata <= '0;
         a_ack     <= 1'b0;
         a_err     <= 1'b0;
         a_rdata   <= '0;
         b_ack     <= 1'b0;
         b_err     <= 1'b0;
         b_rdata   <= '0;
      end else begin
         a_ack <= 1'b0;
         a_err <= 1'b0;
         b_ack <= 1'b0;
         b_err <= 1'b0;
         if (state == IDLE && (a_req || b_req)) begin
            last_b    <= grant_b;
            cur_b     <= grant_b;
            cur_we    <= win_we;
            cur_sel   <= win_sel;
            cur_wdata <= win_wdata;
            cur_ok    <= ({1'b0, win_sel} < NREG);
         end
         // ack/err/rdata launch at the ACCESS->RESP edge so they show in RESP
         if (state == ACCESS) begin
            if (cur_b) begin
               b_ack <= 1'b1;
               b_err <= !cur_ok;
               if (!cur_we) b_rdata <= cur_ok ? rf_d_out : '0;
            end else begin
               a_ack <= 1'b1;
               a_err <= !cur_ok;
               if (!cur_we) a_rdata <= cur_ok ? rf_d_out : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file.
// Vector table for single transactions plus multi-cycle corner sequences.
module tb_regfile_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [2:0]  a_sel = '0;
   logic [15:0] a_wdata = '0;
   logic        a_ack, a_err;
   logic [15:0] a_rdata;
   logic        b_req = 1'b0, b_we = 1'b0;
   logic [2:0]  b_sel = '0;
   logic [15:0] b_wdata = '0;
   logic        b_ack, b_err;
   logic [15:0] b_rdata;
   logic [2:0]  rf_s_in, rf_s_out;
   logic [15:0] rf_d_in, rf_d_out;
   logic        rf_write_en, rf_out_en, busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] regs [8];
   int wr_cnt = 0, out_cnt = 0, both_cnt = 0;
   logic [2:0]  last_wsel;
   logic [15:0] last_wdata;

   always #5 clk = ~clk;

   regfile_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_sel(a_sel), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_sel(b_sel), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
      .rf_s_in(rf_s_in), .rf_s_out(rf_s_out), .rf_d_in(rf_d_in),
      .rf_write_en(rf_write_en), .rf_out_en(rf_out_en),
      .rf_d_out(rf_d_out), .busy(busy)
   );

   // register file model: FR (sel 3) keeps only 4 bits
   assign rf_d_out = (rf_s_out < 3'd6) ? regs[rf_s_out] : 16'h0;

   always @(posedge clk) begin
      if (rf_write_en)
         regs[rf_s_in] <= (rf_s_in == 3'd3) ? {12'h0, rf_d_in[3:0]} : rf_d_in;
   end

   always @(negedge clk) begin
      if (rf_write_en) begin
         wr_cnt++;
         last_wsel  = rf_s_in;
         last_wdata = rf_d_in;
      end
      if (rf_out_en) out_cnt++;
      if (rf_write_en && rf_out_en) both_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      bit          is_b;
      bit          we;
      logic [2:0]  sel;
      logic [15:0] wd;
      bit          err;
      logic [15:0] rd;
   } vec_t;

   vec_t vt [11];
   logic [15:0] last_rd [2];

   task automatic do_reset();
      rst_n = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // called at an IDLE negedge; returns at the next IDLE negedge
   task automatic run_vec(input vec_t v, input int idx);
      int  lat;
      bit  got;
      int  w0, o0;
      logic ack, err;
      w0 = wr_cnt;
      o0 = out_cnt;
      if (v.is_b) begin
         b_req = 1; b_we = v.we; b_sel = v.sel; b_wdata = v.wd;
      end else begin
         a_req = 1; a_we = v.we; a_sel = v.sel; a_wdata = v.wd;
      end
      lat = 1;
      got = 0;
      err = 0;
      while (!got && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
         ack = v.is_b ? b_ack : a_ack;
         err = v.is_b ? b_err : a_err;
         if (ack) got = 1;
      end
      a_req = 0;
      b_req = 0;
      chk($sformatf("v%0d ack_seen", idx), 32'(got), 32'd1);
      chk($sformatf("v%0d latency", idx), lat, 3);
      chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
      if (!v.we) last_rd[v.is_b] = v.err ? 16'h0 : v.rd;
      @(negedge clk);
      chk($sformatf("v%0d a_rdata", idx), 32'(a_rdata), 32'(last_rd[0]));
      chk($sformatf("v%0d b_rdata", idx), 32'(b_rdata), 32'(last_rd[1]));
      chk($sformatf("v%0d wr_strobes", idx), wr_cnt - w0,
          (v.we && !v.err) ? 1 : 0);
      chk($sformatf("v%0d rd_strobes", idx), out_cnt - o0,
          (!v.we && !v.err) ? 1 : 0);
      if (v.we && !v.err)
         chk($sformatf("v%0d wsel", idx), 32'(last_wsel), 32'(v.sel));
      @(negedge clk);
      chk($sformatf("v%0d ack_pulse", idx), 32'({a_ack, b_ack}), 32'd0);
   endtask

   initial begin
      logic [1:0] exp_code;
      for (int i = 0; i < 8; i++) regs[i] = 16'h0;
      last_rd[0] = 16'h0;
      last_rd[1] = 16'h0;
      //          is_b we sel   wdata     err rdata
      vt[0]  = '{0, 1, 3'd1, 16'h1234, 0, 16'h0};
      vt[1]  = '{0, 0, 3'd1, 16'h0,    0, 16'h1234};
      vt[2]  = '{0, 1, 3'd3, 16'hABCD, 0, 16'h0};
      vt[3]  = '{0, 0, 3'd3, 16'h0,    0, 16'h000D};
      vt[4]  = '{1, 0, 3'd6, 16'h0,    1, 16'h0};
      vt[5]  = '{1, 1, 3'd7, 16'hFFFF, 1, 16'h0};
      vt[6]  = '{1, 0, 3'd1, 16'h0,    0, 16'h1234};
      vt[7]  = '{1, 1, 3'd5, 16'h0F0F, 0, 16'h0};
      vt[8]  = '{0, 0, 3'd5, 16'h0,    0, 16'h0F0F};
      vt[9]  = '{0, 0, 3'd0, 16'h0,    0, 16'h0000};
      vt[10] = '{1, 0, 3'd7, 16'h0,    1, 16'h0};

      // reset state
      a_req = 1; b_req = 1; a_sel = 3'd2; b_sel = 3'd4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_outs", 32'({a_ack, a_err, b_ack, b_err, busy,
                           rf_write_en, rf_out_en}), 32'd0);
      chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
      chk("rst_rf", 32'({rf_s_in, rf_s_out, rf_d_in}), 32'd0);
      a_req = 0; b_req = 0;
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_vec(vt[i], i);
      chk("reg1_kept", 32'(regs[1]), 32'h1234);
      chk("reg_fr", 32'(regs[3]), 32'h000D);

      // round-robin with both requests held
      do_reset();
      a_we = 1; a_sel = 3'd0; a_wdata = 16'h0001;
      b_we = 1; b_sel = 3'd2; b_wdata = 16'h0002;
      a_req = 1; b_req = 1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         if (cyc > 1) @(negedge clk);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
         exp_code = (cyc % 3 == 0) ? 2'b10 : 2'b00;
`else
         exp_code = (cyc % 3 != 0) ? 2'b00 :
                    (((cyc / 3) % 2) == 1) ? 2'b10 : 2'b01;
`endif
         chk($sformatf("rr_c%0d", cyc), 32'({a_ack, b_ack}), 32'(exp_code));
      end
      a_req = 0; b_req = 0;
      @(negedge clk);
      chk("rr_acc", 32'(regs[0]), 32'h0001);

      // reset during ACCESS of an A write
      a_we = 1; a_sel = 3'd4; a_wdata = 16'h7777; a_req = 1;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 0; a_req = 0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_rf", 32'({rf_s_in, rf_s_out, rf_d_in,
                             rf_write_en, rf_out_en}), 32'd0);
      chk("mid_rst_ack", 32'(a_ack), 32'd0);
      rst_n = 1;
      @(negedge clk);
      chk("mid_no_ack", 32'(a_ack), 32'd0);
      a_we = 0; a_sel = 3'd1; b_we = 0; b_sel = 3'd2;
      a_req = 1; b_req = 1;
      @(negedge clk);
      @(negedge clk);
      chk("tie_after_rst", 32'({a_ack, b_ack}), 32'b10);
      chk("tie_rdata", 32'(a_rdata), 32'h1234);
      a_req = 0; b_req = 0;
      @(negedge clk);

      // wdata changes after the IDLE sample
      a_we = 1; a_sel = 3'd2; a_wdata = 16'h5555; a_req = 1;
      @(negedge clk);
      a_wdata = 16'hAAAA;
      @(negedge clk);
      chk("stab_ack", 32'(a_ack), 32'd1);
      a_req = 0;
      @(negedge clk);
      chk("stab_reg", 32'(regs[2]), 32'h5555);
      chk("stab_wdata", 32'(last_wdata), 32'h5555);
      chk("strobe_excl", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
